// File: rtl/laser_point_feeder.sv
// ---------------------------------------------------------------------------
// laser_point_feeder
//
// Wrapper stage around the LASER two-circle search core. It collects one job
// of NUM_PTS target points from a valid/ready stream, holds LASER in reset
// while loading, then replays the points one per cycle in LASER read order.
// It waits for LASER's DONE pulse and captures the two circle centres, then
// presents them on a held valid/ready result port. A watchdog turns a hung
// LASER run into an error result so the pipeline always makes progress.
//
// Ports
//   CLK                      clock, everything on the rising edge
//   RST                      synchronous, active-high reset
//   in_valid / in_ready      point stream handshake (ready only in LOAD)
//   in_x / in_y              point coordinates
//   lsr_rst                  LASER reset (high in LOAD and RESULT)
//   lsr_x / lsr_y            point fed to LASER (zero outside STREAM)
//   lsr_done                 LASER completion pulse
//   lsr_c1x..lsr_c2y         LASER result coordinates
//   res_valid / res_ready    result handshake, result held until accepted
//   res_c1x..res_c2y         captured result coordinates
//   res_err                  1 = watchdog abort, coordinates forced to 0
//   busy                     high whenever the feeder is not in LOAD
// ---------------------------------------------------------------------------
module laser_point_feeder #(
    parameter int DATA_WIDTH  = 4,
    parameter int NUM_PTS     = 40,
    parameter int TIMEOUT_CYC = 32768,
    parameter int TO_W        = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    output logic                  lsr_rst,
    output logic [DATA_WIDTH-1:0] lsr_x,
    output logic [DATA_WIDTH-1:0] lsr_y,
    input  logic                  lsr_done,
    input  logic [DATA_WIDTH-1:0] lsr_c1x,
    input  logic [DATA_WIDTH-1:0] lsr_c1y,
    input  logic [DATA_WIDTH-1:0] lsr_c2x,
    input  logic [DATA_WIDTH-1:0] lsr_c2y,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_c1x,
    output logic [DATA_WIDTH-1:0] res_c1y,
    output logic [DATA_WIDTH-1:0] res_c2x,
    output logic [DATA_WIDTH-1:0] res_c2y,
    output logic                  res_err,
    output logic                  busy
);

    localparam int CNT_W = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
    localparam int PT_W  = 2 * DATA_WIDTH;

    localparam logic [CNT_W-1:0] LAST_PT = CNT_W'(NUM_PTS - 1);
    localparam logic [TO_W-1:0]  WD_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      ld_cnt_q;
    logic [CNT_W-1:0]      st_cnt_q;
    logic [TO_W-1:0]       wd_cnt_q;

    logic                  res_valid_q;
    logic                  res_err_q;
    logic [DATA_WIDTH-1:0] res_c1x_q;
    logic [DATA_WIDTH-1:0] res_c1y_q;
    logic [DATA_WIDTH-1:0] res_c2x_q;
    logic [DATA_WIDTH-1:0] res_c2y_q;

    // Point buffer, {x, y} per entry, with a registered read port.
    logic [PT_W-1:0]       pt_mem [NUM_PTS];
    logic [PT_W-1:0]       rd_data_q;
    logic [CNT_W-1:0]      rd_addr_d;
    logic                  load_hs_d;

    assign load_hs_d = (state_q == ST_LOAD) && in_valid;

    // The read port runs one point ahead of st_cnt so that the registered
    // read data lines up with the cycle that point is due on lsr_x/lsr_y.
    // In LOAD the address rests on entry 0, so point 0 is already in the
    // read register on the very first STREAM cycle.
    always_comb begin
        rd_addr_d = '0;
        if (state_q == ST_STREAM && st_cnt_q != LAST_PT) begin
            rd_addr_d = st_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (load_hs_d) begin
            pt_mem[ld_cnt_q] <= {in_x, in_y};
        end
        rd_data_q <= pt_mem[rd_addr_d];
    end

    // Control FSM, counters and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_LOAD;
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
            wd_cnt_q    <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_c1x_q   <= '0;
            res_c1y_q   <= '0;
            res_c2x_q   <= '0;
            res_c2y_q   <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_hs_d) begin
                        if (ld_cnt_q == LAST_PT) begin
                            ld_cnt_q <= '0;
                            st_cnt_q <= '0;
                            state_q  <= ST_STREAM;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + CNT_W'(1);
                        end
                    end
                end

                // lsr_done is deliberately not looked at here: LASER can only
                // legitimately finish after it has read every point.
                ST_STREAM: begin
                    if (st_cnt_q == LAST_PT) begin
                        st_cnt_q <= '0;
                        wd_cnt_q <= '0;
                        state_q  <= ST_WAIT;
                    end else begin
                        st_cnt_q <= st_cnt_q + CNT_W'(1);
                    end
                end

                // Done is tested before the watchdog so a completion that
                // lands on the final watchdog cycle still reports success.
                ST_WAIT: begin
                    if (lsr_done) begin
                        res_c1x_q   <= lsr_c1x;
                        res_c1y_q   <= lsr_c1y;
                        res_c2x_q   <= lsr_c2x;
                        res_c2y_q   <= lsr_c2y;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        wd_cnt_q    <= '0;
                        state_q     <= ST_RESULT;
                    end else if (wd_cnt_q == WD_LAST) begin
                        res_c1x_q   <= '0;
                        res_c1y_q   <= '0;
                        res_c2x_q   <= '0;
                        res_c2y_q   <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        wd_cnt_q    <= '0;
                        state_q     <= ST_RESULT;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + TO_W'(1);
                    end
                end

                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_LOAD;
                    end
                end

                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    // Output decode: only registered state feeds these, never an input.
    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign lsr_rst   = (state_q == ST_LOAD) || (state_q == ST_RESULT);
    assign lsr_x     = (state_q == ST_STREAM) ? rd_data_q[PT_W-1:DATA_WIDTH] : '0;
    assign lsr_y     = (state_q == ST_STREAM) ? rd_data_q[DATA_WIDTH-1:0]    : '0;

    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign res_c1x   = res_c1x_q;
    assign res_c1y   = res_c1y_q;
    assign res_c2x   = res_c2x_q;
    assign res_c2y   = res_c2y_q;

endmodule
